regfile_rd_seq: RTL and testbench



---
 rtl/regfile_rd_seq_pkg.sv | 16 +
 rtl/regfile_rd_seq_if.sv | 55 +++++
 rtl/regfile_rd_seq_sb.sv | 39 +++
 rtl/regfile_rd_seq.sv | 117 +++++++++++
 tb/tb_regfile_rd_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_rd_seq_pkg.sv
// Shared types for the regfile read sequencer: FSM state encodings and register-file sizing.
// Optional RF_SCOREBOARD_EN build adds a busy-vector stall on pending writes.
package regfile_rd_seq_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int REG_NUM    = 32;

    typedef enum logic [1:0] {
        RdSeqIdle = 2'd0,
        RdSeqRd1  = 2'd1,
        RdSeqRd2  = 2'd2,
        RdSeqHold = 2'd3
    } rd_seq_state_t;

endpackage

// File: rtl/regfile_rd_seq_if.sv
// Bundle of request, regfile-port, writeback-snoop and response signals for regfile_rd_seq.
// sb_set_i/sb_rd_i exist only when RF_SCOREBOARD_EN is defined.
interface regfile_rd_seq_if
    import regfile_rd_seq_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) ();

    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_rs1_i;
    logic [ADDR_W-1:0] req_rs2_i;
    logic              req_rs2_en_i;
    logic [ADDR_W-1:0] rf_raddr_o;
    logic [DATA_W-1:0] rf_rdata_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_waddr_i;
    logic [DATA_W-1:0] wb_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_op1_o;
    logic [DATA_W-1:0] rsp_op2_o;
    rd_seq_state_t     dbg_state_o;

    // Handshakes: a transfer happens on any edge where valid and ready are both high;
    // valid must not depend on ready, and payload is held stable while valid waits.
`ifdef RF_SCOREBOARD_EN
    logic              sb_set_i;
    logic [ADDR_W-1:0] sb_rd_i;

    modport master (
        output req_valid_i, req_rs1_i, req_rs2_i, req_rs2_en_i, rf_rdata_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i, rsp_ready_i, sb_set_i, sb_rd_i,
        input  req_ready_o, rf_raddr_o, rsp_valid_o, rsp_op1_o, rsp_op2_o, dbg_state_o
    );
    modport slave (
        input  req_valid_i, req_rs1_i, req_rs2_i, req_rs2_en_i, rf_rdata_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i, rsp_ready_i, sb_set_i, sb_rd_i,
        output req_ready_o, rf_raddr_o, rsp_valid_o, rsp_op1_o, rsp_op2_o, dbg_state_o
    );
`else
    modport master (
        output req_valid_i, req_rs1_i, req_rs2_i, req_rs2_en_i, rf_rdata_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i, rsp_ready_i,
        input  req_ready_o, rf_raddr_o, rsp_valid_o, rsp_op1_o, rsp_op2_o, dbg_state_o
    );
    modport slave (
        input  req_valid_i, req_rs1_i, req_rs2_i, req_rs2_en_i, rf_rdata_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i, rsp_ready_i,
        output req_ready_o, rf_raddr_o, rsp_valid_o, rsp_op1_o, rsp_op2_o, dbg_state_o
    );
`endif

endinterface

// File: rtl/regfile_rd_seq_sb.sv
// rf_scoreboard: busy bit per register, set on issue and cleared on writeback.
// Instantiated by regfile_rd_seq only under RF_SCOREBOARD_EN.
module rf_scoreboard
    import regfile_rd_seq_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_busy
);

    localparam int NUM = 1 << ADDR_W;

    logic [NUM-1:0] r_busy;
    logic [NUM-1:0] w_busy_nxt;

    // Set is applied after clear so a simultaneous set/clear of one register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    // A write landing this cycle reaches the reader through regfile write-through.
    assign o_busy = r_busy[i_lookup_addr] && !(i_clr && (i_clr_addr == i_lookup_addr));

endmodule

// File: rtl/regfile_rd_seq.sv
// Operand-fetch sequencer sharing one regfile read port across rs1/rs2, with writeback snooping.
// Define RF_SCOREBOARD_EN to stall reads of registers that still have a pending write.
module regfile_rd_seq
    import regfile_rd_seq_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    regfile_rd_seq_if.slave  bus
);

    rd_seq_state_t     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rs1, r_rs2;
    logic              r_rs2_en;
    logic [DATA_W-1:0] r_op1, r_op2;
    logic              w_req_ready, w_rsp_valid, w_stall;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_snoop1, w_snoop2;

    assign w_raddr = (r_state == RdSeqRd1) ? r_rs1 :
                     (r_state == RdSeqRd2) ? r_rs2 : '0;

`ifdef RF_SCOREBOARD_EN
    logic w_busy;

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_set         (bus.sb_set_i && (bus.sb_rd_i != '0)),
        .i_set_addr    (bus.sb_rd_i),
        .i_clr         (bus.wb_we_i),
        .i_clr_addr    (bus.wb_waddr_i),
        .i_lookup_addr (w_raddr),
        .o_busy        (w_busy)
    );

    assign w_stall = w_busy && ((r_state == RdSeqRd1) || (r_state == RdSeqRd2));
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            RdSeqIdle: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) w_state_nxt = RdSeqRd1;
            end
            RdSeqRd1: begin
                if (!w_stall) w_state_nxt = r_rs2_en ? RdSeqRd2 : RdSeqHold;
            end
            RdSeqRd2: begin
                if (!w_stall) w_state_nxt = RdSeqHold;
            end
            RdSeqHold: begin
                w_rsp_valid = 1'b1;
                w_req_ready = bus.rsp_ready_i;
                if (bus.rsp_ready_i) w_state_nxt = bus.req_valid_i ? RdSeqRd1 : RdSeqIdle;
            end
            default: w_state_nxt = RdSeqIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= RdSeqIdle;
        else      r_state <= w_state_nxt;
    end

    // x0 is never snooped: the regfile keeps it at zero regardless of writes.
    assign w_snoop1 = bus.wb_we_i && (bus.wb_waddr_i != '0) && (bus.wb_waddr_i == r_rs1);
    assign w_snoop2 = bus.wb_we_i && (bus.wb_waddr_i != '0) && (bus.wb_waddr_i == r_rs2) && r_rs2_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rs2_en <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
        end else begin
            if (w_req_ready && bus.req_valid_i) begin
                r_rs1    <= bus.req_rs1_i;
                r_rs2    <= bus.req_rs2_i;
                r_rs2_en <= bus.req_rs2_en_i;
            end
            case (r_state)
                RdSeqRd1: begin
                    if (!w_stall) begin
                        r_op1 <= bus.rf_rdata_i;
                        if (!r_rs2_en) r_op2 <= '0;
                    end
                end
                RdSeqRd2: begin
                    if (w_snoop1) r_op1 <= bus.wb_wdata_i;
                    if (!w_stall) r_op2 <= bus.rf_rdata_i;
                end
                RdSeqHold: begin
                    if (w_snoop1) r_op1 <= bus.wb_wdata_i;
                    if (w_snoop2) r_op2 <= bus.wb_wdata_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rf_raddr_o  = w_raddr;
    assign bus.rsp_op1_o   = r_op1;
    assign bus.rsp_op2_o   = r_op2;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Bench for regfile_rd_seq: behavioural regfile with write-through, expected-operand queues.
// Define RF_SCOREBOARD_EN to also exercise the busy-register stall.
module tb_regfile_rd_seq;
    import regfile_rd_seq_pkg::*;

    localparam int AW = 5;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    logic [DW-1:0] mem[32];

    always #5 clk = ~clk;

    regfile_rd_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_rd_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Regfile model: x0 reads zero, same-cycle write is forwarded to the read port.
    assign bus.rf_rdata_i = (bus.rf_raddr_o == '0) ? '0 :
                            (bus.wb_we_i && (bus.wb_waddr_i == bus.rf_raddr_o)) ? bus.wb_wdata_i :
                            mem[bus.rf_raddr_o];

    always @(posedge clk) begin
        if (bus.wb_we_i && (bus.wb_waddr_i != '0)) mem[bus.wb_waddr_i] <= bus.wb_wdata_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = a; bus.wb_wdata_i = d;
        @(posedge clk); #1;
        bus.wb_we_i = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic en);
        logic done;
        done = 1'b0;
        bus.req_valid_i = 1'b1; bus.req_rs1_i = rs1; bus.req_rs2_i = rs2; bus.req_rs2_en_i = en;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (bus.req_ready_o === 1'b1) begin
                exp_q1.push_back((rs1 == '0) ? '0 : mem[rs1]);
                exp_q2.push_back((!en || rs2 == '0) ? '0 : mem[rs2]);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL issue_timeout got=not_ready exp=ready");
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.rsp_valid_o); end
        total++; if (bus.rsp_op1_o !== '0) begin bad++; $display("FAIL reset_op1 got=%0h exp=0", bus.rsp_op1_o); end
        total++; if (bus.rsp_op2_o !== '0) begin bad++; $display("FAIL reset_op2 got=%0h exp=0", bus.rsp_op2_o); end
        total++; if (bus.rf_raddr_o !== '0) begin bad++; $display("FAIL reset_raddr got=%0h exp=0", bus.rf_raddr_o); end
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.req_ready_o); end
        total++; if (bus.dbg_state_o !== RdSeqIdle) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state_o, RdSeqIdle); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_two_ops();
        logic [DW-1:0] e1, e2;
        rf_write(5'd3, 64'h11);
        rf_write(5'd5, 64'h22);
        issue(5'd3, 5'd5, 1'b1);
        @(negedge clk);
        total++; if (bus.rf_raddr_o !== 5'd3) begin bad++; $display("FAIL two_raddr1 got=%0d exp=3", bus.rf_raddr_o); end
        @(negedge clk);
        total++; if (bus.rf_raddr_o !== 5'd5) begin bad++; $display("FAIL two_raddr2 got=%0d exp=5", bus.rf_raddr_o); end
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL two_early_valid got=%0b exp=0", bus.rsp_valid_o); end
        @(negedge clk);
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL two_valid_t3 got=%0b exp=1", bus.rsp_valid_o); end
        total++; if (bus.rf_raddr_o !== '0) begin bad++; $display("FAIL two_hold_raddr got=%0d exp=0", bus.rf_raddr_o); end
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL two_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL two_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        release_rsp();
        @(negedge clk);
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL two_after_release got=%0b exp=0", bus.rsp_valid_o); end
    endtask

    task automatic test_no_rs2();
        int lat;
        logic [DW-1:0] e1, e2;
        rf_write(5'd9, 64'hDEAD_BEEF);
        issue(5'd0, 5'd9, 1'b0);
        wait_rsp(lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL nors2_latency got=%0d exp=2", lat); end
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL nors2_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL nors2_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        release_rsp();
    endtask

    task automatic test_snoop();
        int lat;
        logic [DW-1:0] e1, e2;
        rf_write(5'd3, 64'h11);
        rf_write(5'd5, 64'h22);
        issue(5'd3, 5'd5, 1'b1);
        wait_rsp(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL snoop_latency got=%0d exp=3", lat); end
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL snoop_pre_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd3; bus.wb_wdata_i = 64'hAA;
        @(negedge clk);
        total++; if (bus.rsp_op1_o !== 64'hAA) begin bad++; $display("FAIL snoop_op1 got=%0h exp=aa", bus.rsp_op1_o); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL snoop_op2_kept got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 64'hFF;
        @(negedge clk);
        total++; if (bus.rsp_op1_o !== 64'hAA) begin bad++; $display("FAIL snoop_x0_op1 got=%0h exp=aa", bus.rsp_op1_o); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL snoop_x0_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        bus.wb_waddr_i = 5'd5; bus.wb_wdata_i = 64'hBB;
        @(negedge clk);
        total++; if (bus.rsp_op2_o !== 64'hBB) begin bad++; $display("FAIL snoop_op2 got=%0h exp=bb", bus.rsp_op2_o); end
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL snoop_valid_held got=%0b exp=1", bus.rsp_valid_o); end
        bus.wb_we_i = 1'b0;
        release_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [DW-1:0] e1, e2;
        rf_write(5'd1, 64'h101);
        rf_write(5'd2, 64'h202);
        rf_write(5'd4, 64'h404);
        issue(5'd1, 5'd2, 1'b1);
        wait_rsp(lat);
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL b2b_first_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL b2b_first_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1; bus.req_rs1_i = 5'd4; bus.req_rs2_i = 5'd0; bus.req_rs2_en_i = 1'b0;
        #1;
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", bus.req_ready_o); end
        exp_q1.push_back(mem[4]);
        exp_q2.push_back('0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        total++; if (bus.dbg_state_o !== RdSeqRd1) begin bad++; $display("FAIL b2b_state got=%0d exp=%0d", bus.dbg_state_o, RdSeqRd1); end
        total++; if (bus.rf_raddr_o !== 5'd4) begin bad++; $display("FAIL b2b_raddr got=%0d exp=4", bus.rf_raddr_o); end
        wait_rsp(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL b2b_second_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL b2b_second_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        release_rsp();
    endtask

    task automatic test_random();
        int lat, hold;
        logic [AW-1:0] a1, a2;
        logic en;
        logic [DW-1:0] e1, e2;
        for (int n = 0; n < 10; n++) begin
            a1 = AW'($urandom_range(0, 31));
            a2 = AW'($urandom_range(0, 31));
            en = 1'($urandom_range(0, 1));
            rf_write(AW'($urandom_range(1, 31)), {$urandom, $urandom});
            rf_write(a1, {$urandom, $urandom});
            rf_write(a2, {$urandom, $urandom});
            issue(a1, a2, en);
            wait_rsp(lat);
            total++; if (lat !== (en ? 3 : 2)) begin bad++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, en ? 3 : 2); end
            hold = $urandom_range(0, 2);
            repeat (hold) @(negedge clk);
            total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL rand_valid_held n=%0d got=%0b exp=1", n, bus.rsp_valid_o); end
            e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
            total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL rand_op1 n=%0d got=%0h exp=%0h", n, bus.rsp_op1_o, e1); end
            total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL rand_op2 n=%0d got=%0h exp=%0h", n, bus.rsp_op2_o, e2); end
            release_rsp();
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        rf_write(5'd3, 64'h33);
        rf_write(5'd5, 64'h55);
        issue(5'd3, 5'd5, 1'b1);
        void'(exp_q1.pop_back());
        void'(exp_q2.pop_back());
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.dbg_state_o !== RdSeqRd2) begin bad++; $display("FAIL rstmid_in_rd2 got=%0d exp=%0d", bus.dbg_state_o, RdSeqRd2); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.dbg_state_o !== RdSeqIdle) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", bus.dbg_state_o, RdSeqIdle); end
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", bus.rsp_valid_o); end
        total++; if (bus.rsp_op1_o !== '0) begin bad++; $display("FAIL rstmid_op1 got=%0h exp=0", bus.rsp_op1_o); end
        total++; if (bus.rsp_op2_o !== '0) begin bad++; $display("FAIL rstmid_op2 got=%0h exp=0", bus.rsp_op2_o); end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%0b exp=0", seen); end
    endtask

`ifdef RF_SCOREBOARD_EN
    task automatic test_scoreboard();
        int lat;
        logic stuck_ok;
        logic [DW-1:0] e1, e2;
        rf_write(5'd7, 64'h77);
        @(posedge clk); #1;
        bus.sb_set_i = 1'b1; bus.sb_rd_i = 5'd7;
        @(posedge clk); #1;
        bus.sb_set_i = 1'b0;
        issue(5'd7, 5'd0, 1'b0);
        void'(exp_q1.pop_back());
        exp_q1.push_back(64'h55);
        stuck_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.dbg_state_o !== RdSeqRd1) stuck_ok = 1'b0;
        end
        total++; if (stuck_ok !== 1'b1) begin bad++; $display("FAIL sb_stall got=%0d exp=%0d", bus.dbg_state_o, RdSeqRd1); end
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd7; bus.wb_wdata_i = 64'h55;
        @(posedge clk); #1;
        bus.wb_we_i = 1'b0;
        wait_rsp(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL sb_latency got=%0d exp=1", lat); end
        e1 = exp_q1.pop_front(); e2 = exp_q2.pop_front();
        total++; if (bus.rsp_op1_o !== e1) begin bad++; $display("FAIL sb_op1 got=%0h exp=%0h", bus.rsp_op1_o, e1); end
        total++; if (bus.rsp_op2_o !== e2) begin bad++; $display("FAIL sb_op2 got=%0h exp=%0h", bus.rsp_op2_o, e2); end
        release_rsp();
    endtask
`endif

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.req_rs2_en_i = 1'b0;
        bus.wb_we_i      = 1'b0;
        bus.wb_waddr_i   = '0;
        bus.wb_wdata_i   = '0;
        bus.rsp_ready_i  = 1'b0;
`ifdef RF_SCOREBOARD_EN
        bus.sb_set_i     = 1'b0;
        bus.sb_rd_i      = '0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = '0;

        test_reset();
        test_two_ops();
        test_no_rs2();
        test_snoop();
        test_back_to_back();
        test_random();
`ifdef RF_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
